tx_fifo_wr_arb: RTL and testbench



---
 rtl/tx_fifo_wr_arb_if.sv | 24 ++
 rtl/tx_fifo_wr_arb.sv | 96 +++++++++
 tb/tb_tx_fifo_wr_arb.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tx_fifo_wr_arb_if.sv
// tx_fifo_wr_arb_if: requester-side and FIFO-side signals of the TX FIFO write arbiter
interface tx_fifo_wr_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
  logic [NUM_REQ-1:0]            i_last;
  logic [NUM_REQ-1:0]            o_ack;
  logic                          i_almost_full;
  logic                          o_push;
  logic [DATA_WIDTH-1:0]         o_wdata;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_pkt_done;
  logic                          o_pkt_err;
  modport master (
    output i_req, i_data, i_last, i_almost_full,
    input  o_ack, o_push, o_wdata, o_grant, o_pkt_done, o_pkt_err
  );
  modport slave (
    input  i_req, i_data, i_last, i_almost_full,
    output o_ack, o_push, o_wdata, o_grant, o_pkt_done, o_pkt_err
  );
endinterface

// File: rtl/tx_fifo_wr_arb.sv
// tx_fifo_wr_arb: round-robin packet-atomic arbiter for the TX FIFO write port
module tx_fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT    = 64
) (
  input logic              i_clk,
  input logic              i_rst,
  tx_fifo_wr_arb_if.slave  bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_PKT + 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         rr_q, rr_d, gidx_q, gidx_d, pick, idx, gnext;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  push_q, push_d, done_q, done_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, data_g;
  logic                  found, acc, last_g, at_max;
  assign bus.o_ack   = grant_q & bus.i_req & {NUM_REQ{~bus.i_almost_full}};
  assign acc         = |bus.o_ack;
  assign data_g      = bus.i_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign last_g      = bus.i_last[gidx_q];
  assign at_max      = cnt_q == CW'(MAX_PKT - 1);
  assign gnext       = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign bus.o_push     = push_q;
  assign bus.o_wdata    = wdata_q;
  assign bus.o_grant    = grant_q;
  assign bus.o_pkt_done = done_q;
  assign bus.o_pkt_err  = err_q;
  // first requesting index at or after the RR pointer, wrapping
  always_comb begin
    idx   = rr_q;
    pick  = rr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.i_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    push_d  = acc;
    wdata_d = acc ? data_g : wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = XFER;
        gidx_d  = pick;
        grant_d = NUM_REQ'(1) << pick;
      end
    end else if (acc) begin
      cnt_d = cnt_q + 1'b1;
      if (last_g || at_max) begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
        rr_d    = gnext;
        done_d  = last_g;
        err_d   = ~last_g;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      push_q  <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      push_q  <= push_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_tx_fifo_wr_arb.sv
// tb_tx_fifo_wr_arb: randomized scoreboard bench for the TX FIFO write arbiter
module tb_tx_fifo_wr_arb;
  localparam int N = 4, DW = 8, MP = 64;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  logic i_clk = 1'b0, i_rst = 1'b1;
  tx_fifo_wr_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();
  tx_fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_PKT(MP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus)
  );
  always #5 i_clk = ~i_clk;
  beat_t          src[N][$];
  logic [DW-1:0]  exp_data[$];
  bit             exp_err[$];
  int checks = 0, fails = 0, stall_pct = 0, af_pct = 0, m_rr = 0, m_cnt = 0, m_g = 0;
  bit m_busy = 1'b0, af_force = 1'b0;
  logic [N-1:0] m_grant = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (src[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_beat(int k, logic [DW-1:0] d, bit l);
    beat_t b;
    b.d = d;
    b.l = l;
    src[k].push_back(b);
  endtask

  task automatic add_pkt(int k, int len, bit with_last);
    for (int b = 0; b < len; b++) add_beat(k, DW'($urandom), with_last && b == len - 1);
  endtask

  // drive one cycle and advance the transaction-level reference model
  task automatic cycle(bit rst);
    logic [N-1:0] exp_ack;
    beat_t b;
    int j;
    @(negedge i_clk);
    i_rst = rst;
    for (int k = 0; k < N; k++) begin
      bus.i_req[k] = src[k].size() != 0 && $urandom_range(99, 0) >= stall_pct;
      bus.i_data[k*DW +: DW] = src[k].size() != 0 ? src[k][0].d : DW'($urandom);
      bus.i_last[k] = src[k].size() != 0 ? src[k][0].l : 1'($urandom);
    end
    bus.i_almost_full = af_force || $urandom_range(99, 0) < af_pct;
    #1;
    if (rst) begin
      m_busy = 1'b0; m_rr = 0; m_cnt = 0; m_grant = '0;
      exp_data.delete();
      exp_err.delete();
    end else if (!m_busy) begin
      check("ack_idle", bus.o_ack, 0);
      for (int i = 0; i < N; i++) begin
        j = (m_rr + i) % N;
        if (!m_busy && bus.i_req[j]) begin
          m_busy = 1'b1; m_g = j; m_grant = N'(1) << j;
        end
      end
    end else begin
      exp_ack = (bus.i_req[m_g] && !bus.i_almost_full) ? N'(1) << m_g : '0;
      check("ack", bus.o_ack, exp_ack);
      if (exp_ack != 0) begin
        b = src[m_g].pop_front();
        exp_data.push_back(b.d);
        m_cnt++;
        if (b.l || m_cnt == MP) begin
          exp_err.push_back(!b.l);
          m_busy = 1'b0; m_cnt = 0; m_grant = '0; m_rr = (m_g + 1) % N;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pending() || m_busy) && n < 3000) begin cycle(1'b0); n++; end
    if (n >= 3000) begin
      checks++; fails++;
      $display("FAIL drain: timeout with requests still pending");
    end
    repeat (2) cycle(1'b0);
  endtask

  task automatic wait_cnt(int c);
    int n = 0;
    while (m_cnt < c && n < 200) begin cycle(1'b0); n++; end
    if (n >= 200) begin
      checks++; fails++;
      $display("FAIL wait_cnt: beat count %0d never reached %0d", m_cnt, c);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT's registered outputs are sampled
  always begin
    logic [DW-1:0] d;
    bit e;
    @(posedge i_clk);
    #1;
    check("grant", bus.o_grant, m_grant);
    check("push", bus.o_push, exp_data.size() != 0);
    if (exp_data.size() != 0) begin
      d = exp_data.pop_front();
      if (bus.o_push) check("wdata", bus.o_wdata, d);
    end
    e = exp_err.size() != 0 && exp_err[0];
    check("pkt_done", bus.o_pkt_done, exp_err.size() != 0 && !e);
    check("pkt_err", bus.o_pkt_err, e);
    if (exp_err.size() != 0) void'(exp_err.pop_front());
  end

  initial begin
    bus.i_req = '0; bus.i_data = '0; bus.i_last = '0; bus.i_almost_full = 1'b0;
    repeat (3) cycle(1'b1);
    add_beat(0, 8'hA1, 1'b0); add_beat(0, 8'hA2, 1'b0); add_beat(0, 8'hA3, 1'b1);
    drain();
    for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) add_pkt(k, 2, 1'b1);
    drain();
    add_pkt(2, 6, 1'b1);
    wait_cnt(2);
    af_force = 1'b1;
    repeat (5) cycle(1'b0);
    af_force = 1'b0;
    drain();
    add_pkt(1, MP, 1'b0);
    drain();
    add_pkt(1, MP, 1'b1);
    drain();
    add_pkt(0, 4, 1'b1);
    wait_cnt(2);
    cycle(1'b1);
    add_pkt(2, 2, 1'b1);
    drain();
    add_pkt(3, 1, 1'b1);
    add_pkt(0, 1, 1'b1);
    drain();
    stall_pct = 25; af_pct = 15;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++)
        if (src[k].size() == 0 && $urandom_range(9, 0) == 0)
          add_pkt(k, $urandom_range(99, 0) == 0 ? int'($urandom_range(66, 62)) : int'($urandom_range(6, 1)), 1'b1);
      cycle(1'b0);
    end
    stall_pct = 0; af_pct = 0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
